// File: rtl/spi_inert_resp_pkg.sv
// Shared types and constants for the gyro SPI responder.
package inert_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [6:0] ADDR_INT1_CTRL = 7'h0D;
    localparam logic [6:0] ADDR_WHO_AM_I  = 7'h0F;
    localparam logic [6:0] ADDR_CTRL2_G   = 7'h11;
    localparam logic [6:0] ADDR_OUTZ_L    = 7'h26;
    localparam logic [6:0] ADDR_OUTZ_H    = 7'h27;

    localparam logic [4:0] FRAME_LEN = 5'd16;
    localparam logic [4:0] CMD_LEN   = 5'd8;

endpackage

// File: rtl/spi_inert_resp_if.sv
// SPI pins plus data-ready interrupt between inert_intf and the responder.
interface spi_inert_resp_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;
    logic INT;

    modport master (output SS_n, output SCLK, output MOSI, input MISO, input INT);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO, output INT);
endinterface

// File: rtl/spi_inert_resp_synch.sv
// Two-flop synchronisers for the SPI pins plus a third flop for edge detection.
module spi_resp_synch (
    input  logic clk,
    input  logic rst,
    input  logic SS_n,
    input  logic SCLK,
    input  logic MOSI,
    output logic ss_n_s,
    output logic mosi_s,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic ss_fall,
    output logic ss_rise
);

    logic [2:0] ss_q;
    logic [2:0] sclk_q;
    logic [1:0] mosi_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_q   <= 3'b111;
            sclk_q <= 3'b000;
            mosi_q <= 2'b00;
        end else begin
            ss_q   <= {ss_q[1:0], SS_n};
            sclk_q <= {sclk_q[1:0], SCLK};
            mosi_q <= {mosi_q[0], MOSI};
        end
    end

    assign ss_n_s    = ss_q[1];
    assign mosi_s    = mosi_q[1];
    assign sclk_rise =  sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] &  sclk_q[2];
    assign ss_fall   = ~ss_q[1]   &  ss_q[2];
    assign ss_rise   =  ss_q[1]   & ~ss_q[2];

endmodule

// File: rtl/spi_inert_resp.sv
// Gyro emulator behind inert_intf's SPI master: register file, yaw sampler, INT.
//
// state | meaning
// IDLE  | no frame in progress, MISO held low
// CMD   | shifting in R/W + address (rises 1..8)
// DATA  | shifting out rd_byte on falls, write data in on rises 9..16
module spi_inert_resp
    import inert_resp_pkg::*;
#(
    parameter logic [15:0] SAMPLE_PERIOD = 16'd50000,
    parameter logic [7:0]  WHO_AM_I_VAL  = 8'h6A
) (
    input  logic              clk,
    input  logic              rst,
    spi_inert_resp_if.slave   spi,
    input  logic [15:0]       yaw_rate
);

    logic ss_n_s, mosi_s, sclk_rise, sclk_fall, ss_fall, ss_rise;

    spi_resp_synch u_synch (
        .clk       (clk),
        .rst       (rst),
        .SS_n      (spi.SS_n),
        .SCLK      (spi.SCLK),
        .MOSI      (spi.MOSI),
        .ss_n_s    (ss_n_s),
        .mosi_s    (mosi_s),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .ss_fall   (ss_fall),
        .ss_rise   (ss_rise)
    );

    state_t      state, state_nxt;
    logic [4:0]  bit_cnt, bit_cnt_nxt;
    logic [6:0]  shreg, shreg_nxt;
    logic [7:0]  cmd, cmd_nxt;
    logic [7:0]  tx, tx_nxt;
    logic        miso, miso_nxt;

    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        rd_clr;

    logic [7:0]  int1_ctrl, ctrl2_g;
    logic [15:0] outz, yaw_hold, sample_cnt;
    logic        drdy, pend, int_q, tick, cap_now, cap_pend;

    logic [6:0]  lk_addr;
    logic [7:0]  rd_lookup;

    // Lookup happens on the 8th rise, so the address's last bit is still on mosi_s.
    always_comb begin
        lk_addr   = {shreg[5:0], mosi_s};
        rd_lookup = 8'h00;
        case (lk_addr)
            ADDR_INT1_CTRL: rd_lookup = int1_ctrl;
            ADDR_WHO_AM_I:  rd_lookup = WHO_AM_I_VAL;
            ADDR_CTRL2_G:   rd_lookup = ctrl2_g;
            ADDR_OUTZ_L:    rd_lookup = outz[7:0];
            ADDR_OUTZ_H:    rd_lookup = outz[15:8];
            default:        rd_lookup = 8'h00;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        cmd_nxt     = cmd;
        tx_nxt      = tx;
        miso_nxt    = miso;
        wr_en       = 1'b0;
        wr_addr     = cmd[6:0];
        wr_data     = {shreg, mosi_s};
        rd_clr      = 1'b0;

        if (ss_rise) begin
            state_nxt = IDLE;
            miso_nxt  = 1'b0;
            rd_clr    = (state == DATA) && (bit_cnt == FRAME_LEN) &&
                        cmd[7] && (cmd[6:0] == ADDR_OUTZ_H);
        end else begin
            case (state)
                IDLE: begin
                    miso_nxt = 1'b0;
                    if (ss_fall) begin
                        bit_cnt_nxt = 5'd0;
                        shreg_nxt   = 7'd0;
                        state_nxt   = CMD;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        shreg_nxt   = {shreg[5:0], mosi_s};
                        bit_cnt_nxt = bit_cnt + 5'd1;
                        if (bit_cnt == CMD_LEN - 5'd1) begin
                            cmd_nxt   = {shreg, mosi_s};
                            tx_nxt    = shreg[6] ? rd_lookup : 8'h00;
                            state_nxt = DATA;
                        end
                    end
                end
                DATA: begin
                    if (sclk_rise && (bit_cnt < FRAME_LEN)) begin
                        shreg_nxt   = {shreg[5:0], mosi_s};
                        bit_cnt_nxt = bit_cnt + 5'd1;
                        wr_en       = (bit_cnt == FRAME_LEN - 5'd1) && !cmd[7];
                    end
                    if (sclk_fall) begin
                        miso_nxt = tx[7];
                        tx_nxt   = {tx[6:0], 1'b0};
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= 5'd0;
            shreg   <= 7'd0;
            cmd     <= 8'h00;
            tx      <= 8'h00;
            miso    <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            shreg   <= shreg_nxt;
            cmd     <= cmd_nxt;
            tx      <= tx_nxt;
            miso    <= miso_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int1_ctrl <= 8'h00;
            ctrl2_g   <= 8'h00;
        end else if (wr_en) begin
            case (wr_addr)
                ADDR_INT1_CTRL: int1_ctrl <= wr_data;
                ADDR_CTRL2_G:   ctrl2_g   <= wr_data;
                default: ;
            endcase
        end
    end

    assign tick = (ctrl2_g != 8'h00) && (sample_cnt == SAMPLE_PERIOD - 16'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= 16'd0;
        end else if ((ctrl2_g == 8'h00) || tick) begin
            sample_cnt <= 16'd0;
        end else begin
            sample_cnt <= sample_cnt + 16'd1;
        end
    end

    // A tick while selected is parked so OUTZ_L/H never change under an open frame.
    assign cap_now  = tick & ss_n_s;
    assign cap_pend = pend & ss_rise & ~tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outz     <= 16'h0000;
            yaw_hold <= 16'h0000;
            pend     <= 1'b0;
            drdy     <= 1'b0;
            int_q    <= 1'b0;
        end else begin
            if (cap_now) begin
                outz <= yaw_rate;
                pend <= 1'b0;
            end else if (tick) begin
                yaw_hold <= yaw_rate;
                pend     <= 1'b1;
            end else if (cap_pend) begin
                outz <= yaw_hold;
                pend <= 1'b0;
            end
            if (cap_now || cap_pend) begin
                drdy <= 1'b1;
            end else if (rd_clr) begin
                drdy <= 1'b0;
            end
            int_q <= drdy & int1_ctrl[1];
        end
    end

    assign spi.MISO = miso;
    assign spi.INT  = int_q;

endmodule

// File: tb/tb_spi_inert_resp.sv
// Self-checking bench for spi_inert_resp: vector table, randomized register traffic, sample/INT corner cases.
module tb_spi_inert_resp;
    import inert_resp_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] yaw_rate;

    spi_inert_resp_if bus();

    spi_inert_resp #(.SAMPLE_PERIOD(16'd64), .WHO_AM_I_VAL(8'h6A)) dut (
        .clk      (clk),
        .rst      (rst),
        .spi      (bus),
        .yaw_rate (yaw_rate)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] frame;
        int          nbits;
        logic [15:0] exp_word;
    } vec_t;

    vec_t tbl[14];
    logic [7:0] model_regs[128];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_begin();
        bus.SS_n = 1'b0;
        step(8);
    endtask

    task automatic spi_end();
        step(8);
        bus.SS_n = 1'b1;
        step(8);
    endtask

    // Mode 0, SCLK = clk/32; MISO sampled just before each rising edge.
    task automatic spi_bits(input logic [15:0] frame, input int nbits, output logic [15:0] word);
        word = 16'h0000;
        for (int i = 0; i < nbits; i++) begin
            bus.MOSI = frame[15-i];
            step(16);
            word[15-i] = bus.MISO;
            bus.SCLK = 1'b1;
            step(16);
            bus.SCLK = 1'b0;
        end
        bus.MOSI = 1'b0;
    endtask

    task automatic spi_frame(input logic [15:0] frame, output logic [15:0] word);
        spi_begin();
        spi_bits(frame, 16, word);
        spi_end();
    endtask

    task automatic wait_int(input int max, output int n, output bit found);
        found = 1'b0;
        n = 0;
        while (!found && n < max) begin
            step(1);
            n++;
            if (bus.INT === 1'b1) found = 1'b1;
        end
    endtask

    function automatic logic [7:0] model_read(input logic [6:0] addr);
        if (addr == ADDR_WHO_AM_I) return 8'h6A;
        return model_regs[addr];
    endfunction

    task automatic model_write(input logic [6:0] addr, input logic [7:0] data);
        if (addr == ADDR_INT1_CTRL || addr == ADDR_CTRL2_G) model_regs[addr] = data;
    endtask

    initial begin
        #900us;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] w;
        logic [6:0]  addr;
        logic [7:0]  data;
        logic        rw;
        int          n, highs;
        bit          found;

        tbl[0]  = '{16'h8F00, 16, 16'h006A};
        tbl[1]  = '{16'h9100, 16, 16'h0000};
        tbl[2]  = '{16'h0D02, 16, 16'h0000};
        tbl[3]  = '{16'h8D00, 16, 16'h0002};
        tbl[4]  = '{16'h0F55, 16, 16'h0000};
        tbl[5]  = '{16'h8F00, 16, 16'h006A};
        tbl[6]  = '{16'h2699, 16, 16'h0000};
        tbl[7]  = '{16'hA600, 16, 16'h0000};
        tbl[8]  = '{16'h0577, 16, 16'h0000};
        tbl[9]  = '{16'h8500, 16, 16'h0000};
        tbl[10] = '{16'h0DFF, 10, 16'h0000};
        tbl[11] = '{16'h8D00, 16, 16'h0002};
        tbl[12] = '{16'h0D00, 16, 16'h0000};
        tbl[13] = '{16'h8D00, 16, 16'h0000};
        for (int i = 0; i < 128; i++) model_regs[i] = 8'h00;

        rst = 1'b1; bus.SS_n = 1'b1; bus.SCLK = 1'b0; bus.MOSI = 1'b0; yaw_rate = 16'h0000;
        step(3);
        chk("reset_miso", {31'd0, bus.MISO}, 32'd0);
        chk("reset_int",  {31'd0, bus.INT},  32'd0);
        rst = 1'b0;
        step(5);

        for (int i = 0; i < 14; i++) begin
            spi_begin();
            spi_bits(tbl[i].frame, tbl[i].nbits, w);
            spi_end();
            chk($sformatf("tbl%0d_word", i), {16'd0, w}, {16'd0, tbl[i].exp_word});
            chk($sformatf("tbl%0d_miso_idle", i), {31'd0, bus.MISO}, 32'd0);
        end

        highs = 0;
        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 4))
                0: addr = ADDR_INT1_CTRL;
                1: addr = ADDR_WHO_AM_I;
                2: addr = ADDR_OUTZ_L;
                3: addr = ADDR_OUTZ_H;
                default: addr = 7'($urandom_range(0, 127));
            endcase
            if (addr == ADDR_CTRL2_G) addr = 7'h12;
            rw   = 1'($urandom_range(0, 1));
            data = 8'($urandom_range(0, 255));
            spi_frame({rw, addr, data}, w);
            chk($sformatf("rand%0d_%0h", k, {rw, addr, data}), {16'd0, w},
                {16'd0, (rw ? {8'h00, model_read(addr)} : 16'h0000)});
            if (!rw) model_write(addr, data);
            if (bus.INT === 1'b1) highs++;
        end
        chk("rand_int_low", highs, 0);

        spi_frame(16'h0D02, w);
        model_write(ADDR_INT1_CTRL, 8'h02);
        spi_frame(16'h8D00, w);
        chk("int1_readback", {16'd0, w}, 32'h0002);

        yaw_rate = 16'h1234;
        spi_frame(16'h1150, w);
        chk("int_before_tick", {31'd0, bus.INT}, 32'd0);
        wait_int(300, n, found);
        chk("int_rise_found", {31'd0, found}, 32'd1);
        chk("int_rise_window", {31'd0, (n >= 30 && n <= 44)}, 32'd1);

        // Park SS_n low across exactly one tick, then change yaw before release.
        yaw_rate = 16'h1111;
        step(30);
        bus.SS_n = 1'b0;
        step(50);
        yaw_rate = 16'h2222;
        step(10);
        bus.SS_n = 1'b1;
        step(5);
        spi_begin();
        spi_bits(16'hA600, 16, w);
        spi_end();
        chk("deferred_outz_l", {16'd0, w}, 32'h0011);
        chk("deferred_drdy_int", {31'd0, bus.INT}, 32'd1);

        yaw_rate = 16'h1234;
        spi_frame(16'h1100, w);
        spi_frame(16'hA600, w);
        chk("outz_l", {16'd0, w}, 32'h0034);
        chk("int_held", {31'd0, bus.INT}, 32'd1);
        spi_frame(16'hA700, w);
        chk("outz_h", {16'd0, w}, 32'h0012);
        chk("int_cleared", {31'd0, bus.INT}, 32'd0);
        step(150);
        chk("int_stays_low", {31'd0, bus.INT}, 32'd0);

        spi_begin();
        spi_bits(16'h0D00, 10, w);
        spi_end();
        spi_frame(16'h8D00, w);
        chk("abort_keeps_int1", {16'd0, w}, 32'h0002);

        spi_frame(16'h1150, w);
        wait_int(200, n, found);
        chk("pre_reset_int", {31'd0, found}, 32'd1);
        spi_begin();
        spi_bits(16'h9100, 5, w);
        rst = 1'b1;
        bus.SS_n = 1'b1; bus.SCLK = 1'b0; bus.MOSI = 1'b0;
        step(2);
        chk("midrst_miso", {31'd0, bus.MISO}, 32'd0);
        chk("midrst_int",  {31'd0, bus.INT},  32'd0);
        step(2);
        rst = 1'b0;
        step(10);
        spi_frame(16'h9100, w);
        chk("midrst_ctrl2", {16'd0, w}, 32'h0000);
        spi_frame(16'h8D00, w);
        chk("midrst_int1", {16'd0, w}, 32'h0000);
        spi_frame(16'h0D02, w);
        highs = 0;
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (bus.INT === 1'b1) highs++;
        end
        chk("sampler_idle", highs, 0);
        spi_frame(16'h1101, w);
        wait_int(200, n, found);
        chk("sampler_restart", {31'd0, found}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
